// File: rtl/prog_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// prog_sequencer : loads data memory, starts the processor, waits for Ack,
//                  then streams a result window back out.   Rev 1.0
// ============================================================================
module prog_sequencer #(
    parameter int          AW        = 8,
    parameter int          LOAD_BASE = 0,
    parameter int          LOAD_LEN  = 64,
    parameter int          DUMP_BASE = 64,
    parameter int          DUMP_LEN  = 64,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          go,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          dut_start,
    input  logic          dut_ack,
    output logic          mem_sel,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [15:0]   run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DUMP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] LOAD_LAST = 16'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
    localparam logic [15:0] DUMP_LAST = 16'((DUMP_LEN > 0) ? DUMP_LEN - 1 : 0);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [15:0] run_next;
    logic        terr_next;
    logic        first_run, first_next;
    logic [15:0] run_sat;

    assign run_sat = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            run_cycles  <= '0;
            timeout_err <= 1'b0;
            first_run   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            run_cycles  <= run_next;
            timeout_err <= terr_next;
            first_run   <= first_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        run_next   = run_cycles;
        terr_next  = timeout_err;
        first_next = first_run;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        dut_start  = 1'b0;
        mem_sel    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (go) begin
                    cnt_next   = '0;
                    run_next   = '0;
                    terr_next  = 1'b0;
                    state_next = (LOAD_LEN == 0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                mem_sel   = 1'b1;
                in_ready  = 1'b1;
                mem_addr  = AW'(LOAD_BASE) + AW'(cnt);
                mem_wdata = in_data;
                mem_we    = in_valid;
                if (in_valid) begin
                    cnt_next = cnt + 16'd1;
                    if (cnt == LOAD_LAST)
                        state_next = S_START;
                end
            end
            S_START: begin
                dut_start  = 1'b1;
                first_next = 1'b1;
                state_next = S_RUN;
            end
            S_RUN: begin
                run_next   = run_sat;
                first_next = 1'b0;
                // Ack seen in the first RUN cycle may be left over from the previous program.
                if (dut_ack && !first_run) begin
                    cnt_next   = '0;
                    state_next = (DUMP_LEN == 0) ? S_DONE : S_DUMP;
                end else if (run_sat >= TIMEOUT) begin
                    terr_next  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DUMP: begin
                mem_sel   = 1'b1;
                mem_addr  = AW'(DUMP_BASE) + AW'(cnt);
                out_valid = 1'b1;
                out_data  = mem_rdata;
                if (out_ready) begin
                    cnt_next = cnt + 16'd1;
                    if (cnt == DUMP_LAST)
                        state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Strobes are suppressed while Reset is held so an aborted sequence has no side effects.
        if (Reset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            dut_start = 1'b0;
            mem_sel   = 1'b0;
            mem_we    = 1'b0;
            done      = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_prog_sequencer : directed bench with memory/processor model and scoreboards.
// ============================================================================
module tb_prog_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, go, in_valid, out_ready, dut_ack;
    logic [7:0] in_data;
    logic       in_ready, out_valid, dut_start, mem_sel, mem_we;
    logic       busy, done, timeout_err;
    logic [7:0] out_data, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] run_cycles;

    always #5 Clk = ~Clk;

    prog_sequencer #(
        .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .DUMP_BASE(64), .DUMP_LEN(4), .TIMEOUT(16'd20)
    ) dut (
        .Clk(Clk), .Reset(Reset), .go(go),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .dut_start(dut_start), .dut_ack(dut_ack),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .timeout_err(timeout_err), .run_cycles(run_cycles)
    );

    // Data memory; the "processor" writes mem[64+i] = mem[i] ^ A5 when started.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge Clk) begin
        if (mem_sel && mem_we)
            mem[mem_addr] <= mem_wdata;
        if (dut_start)
            for (int i = 0; i < 4; i++)
                mem[64 + i] <= mem[i] ^ 8'hA5;
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_dump[$];
    int ov_cnt = 0, done_cnt = 0, start_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard
    always @(negedge Clk) begin
        if (mem_sel && mem_we) begin
            if (exp_wr.size() == 0)
                check("wr_unexpected", {31'd0, mem_we}, 32'd0);
            else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end
        end
    end

    // Dump scoreboard and hold-stability monitor
    logic       hold_v = 1'b0;
    logic [7:0] hold_d, hold_a;
    always @(negedge Clk) begin
        if (hold_v && out_valid) begin
            check("hold_data", {24'd0, out_data}, {24'd0, hold_d});
            check("hold_addr", {24'd0, mem_addr}, {24'd0, hold_a});
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_a = mem_addr;
        if (out_valid && out_ready) begin
            if (exp_dump.size() == 0)
                check("dump_unexpected", {31'd0, out_valid}, 32'd0);
            else
                check("dump_data", {24'd0, out_data}, {24'd0, exp_dump.pop_front()});
        end
        if (out_valid) ov_cnt++;
        if (done) done_cnt++;
        if (dut_start) start_cnt++;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic nck;
        @(negedge Clk);
    endtask

    task automatic load_bytes(input int n, input logic [7:0] seed, input bit gaps, input bit want_dump);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = seed + 8'(8'h11 * (i + 1));
            if (gaps) begin
                in_valid = 1'b0;
                tick;
            end
            in_valid = 1'b1;
            in_data  = b;
            exp_wr.push_back({8'(i), b});
            if (want_dump) exp_dump.push_back(b ^ 8'hA5);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            nck;
            if (done) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        Reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; dut_ack = 1'b0;

        // 1: reset state, then go
        repeat (3) tick;
        nck;
        check("reset_outs", {13'd0, busy, done, in_ready, out_valid, dut_start, mem_sel, mem_we,
                              timeout_err, out_data, mem_addr}, 32'd0);
        check("reset_misc", {8'd0, mem_wdata, run_cycles}, 32'd0);
        tick;
        Reset = 1'b0;
        in_valid = 1'b1; in_data = 8'h77;
        tick;
        in_valid = 1'b0;
        go = 1'b1;
        tick;
        go = 1'b0;
        nck;
        check("go_busy", {31'd0, busy}, 32'd1);
        check("load_ready", {31'd0, in_ready}, 32'd1);

        // 2: load with gaps, single start pulse
        load_bytes(4, 8'h00, 1'b1, 1'b1);
        nck;
        check("t2_start", {31'd0, dut_start}, 32'd1);
        tick;
        nck;
        check("t2_start_off", {31'd0, dut_start}, 32'd0);
        check("t2_run_memsel", {31'd0, mem_sel}, 32'd0);

        // 3: ack on 10th RUN cycle; go during RUN ignored; dump with stall
        repeat (3) tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        repeat (5) tick;
        dut_ack = 1'b1;
        tick;
        dut_ack = 1'b0;
        nck;
        check("t3_run_cycles", {16'd0, run_cycles}, 32'd10);
        check("t3_out_valid", {31'd0, out_valid}, 32'd1);
        tick;
        tick;
        out_ready = 1'b1;
        wait_done(20, "t3_done");
        tick;
        out_ready = 1'b0;
        nck;
        check("t3_idle", {31'd0, busy}, 32'd0);
        check("t3_done_once", done_cnt, 32'd1);
        check("t3_dump_drained", exp_dump.size(), 32'd0);

        // 4: stale ack held through go and START
        dut_ack = 1'b1;
        go = 1'b1;
        tick;
        go = 1'b0;
        load_bytes(4, 8'h05, 1'b0, 1'b1);
        nck;
        check("t4_start", {31'd0, dut_start}, 32'd1);
        tick;
        tick;
        tick;
        dut_ack = 1'b0;
        nck;
        check("t4_run_cycles", {16'd0, run_cycles}, 32'd2);
        check("t4_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_done(20, "t4_done");
        tick;
        out_ready = 1'b0;

        // 5: timeout
        ov0 = ov_cnt;
        go = 1'b1;
        tick;
        go = 1'b0;
        load_bytes(4, 8'h40, 1'b0, 1'b0);
        nck;
        check("t5_start", {31'd0, dut_start}, 32'd1);
        wait_done(40, "t5_done");
        check("t5_timeout_err", {31'd0, timeout_err}, 32'd1);
        check("t5_run_cycles", {16'd0, run_cycles}, 32'd20);
        check("t5_no_out", ov_cnt - ov0, 32'd0);
        tick;
        nck;
        check("t5_sticky", {31'd0, timeout_err}, 32'd1);
        check("t5_idle", {31'd0, busy}, 32'd0);

        // 6: reset during LOAD after 2 bytes
        go = 1'b1;
        tick;
        go = 1'b0;
        nck;
        check("t6_err_cleared", {31'd0, timeout_err}, 32'd0);
        load_bytes(2, 8'h20, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data = 8'h99;
        Reset = 1'b1;
        nck;
        check("t6_we_in_reset", {31'd0, mem_we}, 32'd0);
        tick;
        Reset = 1'b0;
        nck;
        check("t6_idle", {30'd0, busy, mem_we}, 32'd0);
        in_valid = 1'b0;
        tick;
        go = 1'b1;
        tick;
        go = 1'b0;
        load_bytes(4, 8'h60, 1'b1, 1'b1);
        nck;
        check("t6_start", {31'd0, dut_start}, 32'd1);
        tick;
        tick;
        tick;
        dut_ack = 1'b1;
        tick;
        dut_ack = 1'b0;
        nck;
        check("t6_run_cycles", {16'd0, run_cycles}, 32'd3);
        out_ready = 1'b1;
        wait_done(20, "t6_done");
        tick;
        out_ready = 1'b0;
        tick;

        check("final_done_cnt", done_cnt, 32'd4);
        check("final_start_cycles", start_cnt, 32'd4);
        check("final_wr_drained", exp_wr.size(), 32'd0);
        check("final_dump_drained", exp_dump.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
